// File: rtl/store_align_buffer.sv
// Store-side lane alignment and strobe generation feeding a small in-order
// store FIFO that drains to data memory over a valid/ready write channel.
module store_align_buffer #(
    parameter int DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     st_valid,
    output logic                     st_ready,
    input  logic [1:0]               st_size,
    input  logic [31:0]              st_addr,
    input  logic [31:0]              st_data,
    output logic                     misalign,
    output logic                     mem_wvalid,
    input  logic                     mem_wready,
    output logic [31:0]              mem_waddr,
    output logic [31:0]              mem_wdata,
    output logic [3:0]               mem_wstrb,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [29:0]   addr_q [DEPTH];
    logic [31:0]   data_q [DEPTH];
    logic [3:0]    strb_q [DEPTH];

    logic          legal;
    logic          accept;
    logic          enq;
    logic          deq;
    logic [31:0]   lane_data;
    logic [3:0]    lane_strb;

    always_comb begin
        legal     = 1'b0;
        lane_data = st_data;
        lane_strb = 4'b1111;
        case (st_size)
            2'b00: begin
                legal     = 1'b1;
                lane_data = {4{st_data[7:0]}};
                lane_strb = 4'b0001 << st_addr[1:0];
            end
            2'b01: begin
                legal     = ~st_addr[0];
                lane_data = {2{st_data[15:0]}};
                lane_strb = st_addr[1] ? 4'b1100 : 4'b0011;
            end
            2'b10: begin
                legal     = (st_addr[1:0] == 2'b00);
            end
            default: begin
                legal     = 1'b0;
            end
        endcase
    end

    // Ready looks only at registered occupancy, so a same-cycle drain never
    // opens a slot while full.
    assign st_ready   = (count < CW'(DEPTH));
    assign accept     = st_valid && st_ready;
    assign enq        = accept && legal;
    assign deq        = mem_wvalid && mem_wready;

    assign empty      = (count == '0);
    assign mem_wvalid = ~empty;
    assign mem_waddr  = mem_wvalid ? {addr_q[rd_ptr], 2'b00} : 32'h0;
    assign mem_wdata  = mem_wvalid ? data_q[rd_ptr] : 32'h0;
    assign mem_wstrb  = mem_wvalid ? strb_q[rd_ptr] : 4'h0;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
            misalign <= 1'b0;
        end else begin
            misalign <= accept && !legal;
            if (enq) begin
                addr_q[wr_ptr] <= st_addr[31:2];
                data_q[wr_ptr] <= lane_data;
                strb_q[wr_ptr] <= lane_strb;
                wr_ptr         <= wr_ptr + PW'(1);
            end
            if (deq) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({enq, deq})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_store_align_buffer.sv
// Directed bench for store_align_buffer; a forked monitor checks every memory
// write against a queue of hand-computed expected writes.
module tb_store_align_buffer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        st_valid;
    logic        st_ready;
    logic [1:0]  st_size;
    logic [31:0] st_addr;
    logic [31:0] st_data;
    logic        misalign;
    logic        mem_wvalid;
    logic        mem_wready;
    logic [31:0] mem_waddr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        empty;
    logic [1:0]  count;

    typedef struct {
        logic [31:0] a;
        logic [31:0] d;
        logic [3:0]  s;
    } exp_t;

    exp_t sb[$];
    int   tests = 0;
    int   fails = 0;

    store_align_buffer #(.DEPTH(2)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .st_valid   (st_valid),
        .st_ready   (st_ready),
        .st_size    (st_size),
        .st_addr    (st_addr),
        .st_data    (st_data),
        .misalign   (misalign),
        .mem_wvalid (mem_wvalid),
        .mem_wready (mem_wready),
        .mem_waddr  (mem_waddr),
        .mem_wdata  (mem_wdata),
        .mem_wstrb  (mem_wstrb),
        .empty      (empty),
        .count      (count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic monitor();
        logic        stall = 1'b0;
        logic [31:0] sa = '0;
        logic [31:0] sd = '0;
        logic [3:0]  ss = '0;
        exp_t        e;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                stall = 1'b0;
                continue;
            end
            if (!mem_wvalid) chk("idle_outputs_zero", {mem_waddr ^ mem_wdata, 28'h0, mem_wstrb}, 32'h0);
            if (stall) begin
                chk("stall_wvalid_held", {31'h0, mem_wvalid}, 32'h1);
                chk("stall_waddr_stable", mem_waddr, sa);
                chk("stall_wdata_stable", mem_wdata, sd);
                chk("stall_wstrb_stable", {28'h0, mem_wstrb}, {28'h0, ss});
            end
            if (mem_wvalid && mem_wready) begin
                chk("write_expected", {31'h0, sb.size() != 0}, 32'h1);
                if (sb.size() != 0) begin
                    e = sb.pop_front();
                    chk("write_addr", mem_waddr, e.a);
                    chk("write_data", mem_wdata, e.d);
                    chk("write_strb", {28'h0, mem_wstrb}, {28'h0, e.s});
                end
            end
            stall = mem_wvalid && !mem_wready;
            sa = mem_waddr;
            sd = mem_wdata;
            ss = mem_wstrb;
        end
    endtask

    // Holds the request until accepted; leaves inputs idle at posedge+1 of the accept edge.
    task automatic issue(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] d,
                         input logic legal, input logic [31:0] ea, input logic [31:0] ed,
                         input logic [3:0] es);
        logic ok = 1'b0;
        st_valid = 1'b1;
        st_size  = sz;
        st_addr  = a;
        st_data  = d;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (st_ready) begin
                ok = 1'b1;
                break;
            end
            @(posedge clk); #1;
        end
        chk("issue_accepted", {31'h0, ok}, 32'h1);
        if (ok && legal) sb.push_back('{ea, ed, es});
        @(posedge clk); #1;
        st_valid = 1'b0;
    endtask

    task automatic wait_empty();
        logic ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (empty) begin
                ok = 1'b1;
                break;
            end
        end
        chk("drain_to_empty", {31'h0, ok}, 32'h1);
        @(posedge clk); #1;
    endtask

    initial begin
        rst_n      = 1'b0;
        st_valid   = 1'b0;
        st_size    = 2'b00;
        st_addr    = '0;
        st_data    = '0;
        mem_wready = 1'b0;
        fork
            monitor();
        join_none

        // Reset state
        @(posedge clk); #1;
        @(posedge clk); #1;
        @(negedge clk);
        chk("rst_count", {30'h0, count}, 32'h0);
        chk("rst_empty", {31'h0, empty}, 32'h1);
        chk("rst_st_ready", {31'h0, st_ready}, 32'h1);
        chk("rst_wvalid", {31'h0, mem_wvalid}, 32'h0);
        chk("rst_misalign", {31'h0, misalign}, 32'h0);
        chk("rst_waddr", mem_waddr, 32'h0);
        chk("rst_wdata", mem_wdata, 32'h0);
        chk("rst_wstrb", {28'h0, mem_wstrb}, 32'h0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // SB at offset 3, one-cycle latency to the write channel
        issue(2'b00, 32'h0000_1003, 32'hAABB_CC5A, 1'b1, 32'h0000_1000, 32'h5A5A_5A5A, 4'b1000);
        @(negedge clk);
        chk("sb_wvalid", {31'h0, mem_wvalid}, 32'h1);
        chk("sb_waddr", mem_waddr, 32'h0000_1000);
        chk("sb_wdata", mem_wdata, 32'h5A5A_5A5A);
        chk("sb_wstrb", {28'h0, mem_wstrb}, 32'h8);
        chk("sb_count", {30'h0, count}, 32'h1);
        @(posedge clk); #1;
        mem_wready = 1'b1;
        wait_empty();

        // Halfword lanes, then misaligned halfword
        issue(2'b01, 32'h0000_2002, 32'h1234_BEEF, 1'b1, 32'h0000_2000, 32'hBEEF_BEEF, 4'b1100);
        issue(2'b01, 32'h0000_2001, 32'h1234_BEEF, 1'b0, 32'h0, 32'h0, 4'h0);
        @(negedge clk);
        chk("sh_mis_pulse", {31'h0, misalign}, 32'h1);
        chk("sh_mis_count", {30'h0, count}, 32'h0);
        chk("sh_mis_wvalid", {31'h0, mem_wvalid}, 32'h0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("sh_mis_pulse_end", {31'h0, misalign}, 32'h0);
        @(posedge clk); #1;

        issue(2'b00, 32'h0000_3001, 32'h0000_0077, 1'b1, 32'h0000_3000, 32'h7777_7777, 4'b0010);
        issue(2'b01, 32'h0000_4000, 32'h0000_CAFE, 1'b1, 32'h0000_4000, 32'hCAFE_CAFE, 4'b0011);
        issue(2'b10, 32'h0000_5002, 32'h5555_5555, 1'b0, 32'h0, 32'h0, 4'h0);
        @(negedge clk);
        chk("sw_mis_pulse", {31'h0, misalign}, 32'h1);
        chk("sw_mis_count", {30'h0, count}, 32'h0);
        @(posedge clk); #1;
        wait_empty();

        // Backpressure: fill, stall a third store, then release
        mem_wready = 1'b0;
        issue(2'b10, 32'h0000_0100, 32'h1111_1111, 1'b1, 32'h0000_0100, 32'h1111_1111, 4'b1111);
        issue(2'b10, 32'h0000_0104, 32'h2222_2222, 1'b1, 32'h0000_0104, 32'h2222_2222, 4'b1111);
        st_valid = 1'b1;
        st_size  = 2'b10;
        st_addr  = 32'h0000_0108;
        st_data  = 32'h3333_3333;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("full_st_ready", {31'h0, st_ready}, 32'h0);
            chk("full_count", {30'h0, count}, 32'h2);
            chk("full_head_addr", mem_waddr, 32'h0000_0100);
            @(posedge clk); #1;
        end
        mem_wready = 1'b1;
        begin
            logic ok = 1'b0;
            for (int i = 0; i < 20; i++) begin
                @(negedge clk);
                if (st_ready) begin
                    ok = 1'b1;
                    break;
                end
                @(posedge clk); #1;
            end
            chk("third_accepted", {31'h0, ok}, 32'h1);
            if (ok) sb.push_back('{32'h0000_0108, 32'h3333_3333, 4'b1111});
            @(posedge clk); #1;
            st_valid = 1'b0;
        end
        wait_empty();

        // Streaming at count 1 across pointer wrap
        st_valid = 1'b1;
        st_size  = 2'b10;
        for (int i = 0; i < 8; i++) begin
            st_addr = 32'h0000_8000 + 32'(4 * i);
            st_data = 32'hA500_0000 + 32'(i);
            @(negedge clk);
            chk("stream_st_ready", {31'h0, st_ready}, 32'h1);
            chk("stream_count", {30'h0, count}, (i == 0) ? 32'h0 : 32'h1);
            sb.push_back('{32'h0000_8000 + 32'(4 * i), 32'hA500_0000 + 32'(i), 4'b1111});
            @(posedge clk); #1;
        end
        st_valid = 1'b0;
        @(negedge clk);
        chk("stream_tail_count", {30'h0, count}, 32'h1);
        @(posedge clk); #1;
        wait_empty();

        // Reset mid-operation with a full buffer
        mem_wready = 1'b0;
        issue(2'b10, 32'h0000_9000, 32'h9999_0000, 1'b1, 32'h0000_9000, 32'h9999_0000, 4'b1111);
        issue(2'b10, 32'h0000_9004, 32'h9999_0004, 1'b1, 32'h0000_9004, 32'h9999_0004, 4'b1111);
        @(negedge clk);
        chk("prerst_count", {30'h0, count}, 32'h2);
        chk("prerst_wvalid", {31'h0, mem_wvalid}, 32'h1);
        @(posedge clk); #1;
        rst_n = 1'b0;
        sb.delete();
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("midrst_wvalid", {31'h0, mem_wvalid}, 32'h0);
        chk("midrst_count", {30'h0, count}, 32'h0);
        chk("midrst_st_ready", {31'h0, st_ready}, 32'h1);
        chk("midrst_empty", {31'h0, empty}, 32'h1);
        @(posedge clk); #1;
        mem_wready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("no_replay", {31'h0, mem_wvalid}, 32'h0);
            @(posedge clk); #1;
        end

        // Reserved size with a same-cycle dequeue
        mem_wready = 1'b0;
        issue(2'b10, 32'h0000_A000, 32'hDEAD_BEEF, 1'b1, 32'h0000_A000, 32'hDEAD_BEEF, 4'b1111);
        mem_wready = 1'b1;
        issue(2'b11, 32'h0000_0000, 32'h1234_5678, 1'b0, 32'h0, 32'h0, 4'h0);
        @(negedge clk);
        chk("rsv_mis_pulse", {31'h0, misalign}, 32'h1);
        chk("rsv_deq_count", {30'h0, count}, 32'h0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("rsv_pulse_end", {31'h0, misalign}, 32'h0);
        @(posedge clk); #1;

        // Back-to-back illegal requests: one pulse each
        st_valid = 1'b1;
        st_size  = 2'b11;
        st_addr  = 32'h0;
        @(posedge clk); #1;
        @(negedge clk);
        chk("b2b_pulse_1", {31'h0, misalign}, 32'h1);
        @(posedge clk); #1;
        st_valid = 1'b0;
        @(negedge clk);
        chk("b2b_pulse_2", {31'h0, misalign}, 32'h1);
        chk("b2b_count", {30'h0, count}, 32'h0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("b2b_pulse_end", {31'h0, misalign}, 32'h0);
        @(posedge clk); #1;

        chk("scoreboard_drained", sb.size(), 32'h0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
